mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares the single DDR command/data/status channel between NUM_REQ requesters in the net_clk domain, e.g. TCP stack (req 0) and a user role (req 1).
- Sits between the requesters and mem_single_inf.
- Arbitrates read and write commands independently, round-robin.
- Steers returning read data, read status, write data and write status to the owner, using in-order route FIFOs.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 64, command address width.
- LEN_W, 23, command length width (bytes).
- DATA_W, 512, data width; keep width is DATA_W/8.
- ROUTE_DEPTH, 16, entries per route FIFO (power of two); bounds outstanding commands per path.

Ports:
- net_clk  in  1  clock.
- net_aresetn  in  1  asynchronous active-low reset.
- s_rd_cmd_valid/ready  in/out  NUM_REQ  per-requester read command handshake.
- s_rd_cmd_addr  in  NUM_REQ*ADDR_W  packed; requester i at slice i.
- s_rd_cmd_len  in  NUM_REQ*LEN_W  packed.
- s_wr_cmd_valid/ready, s_wr_cmd_addr, s_wr_cmd_len  as read, write command.
- s_wr_data_valid/ready/last  in/out/in  NUM_REQ  write data handshake.
- s_wr_data_data  in  NUM_REQ*DATA_W  packed write data.
- s_wr_data_keep  in  NUM_REQ*DATA_W/8  packed write keep.
- m_rd_data_valid/ready/last  out/in/out  NUM_REQ  read data to requesters; data/keep broadcast on m_rd_data_data (DATA_W), m_rd_data_keep (DATA_W/8).
- m_rd_sts_valid/ready  out/in  NUM_REQ; m_rd_sts_data  out  8  broadcast.
- m_wr_sts_valid/ready  out/in  NUM_REQ; m_wr_sts_data  out  8  broadcast.
- mem_rd_cmd_valid/ready/addr/len, mem_wr_cmd_valid/ready/addr/len  out/in/out/out  1/1/ADDR_W/LEN_W  to memory.
- mem_wr_data_valid/ready/data/keep/last  out/in/out/out/out  write data to memory.
- mem_rd_data_valid/ready/data/keep/last  in/out/in/in/in  read data from memory.
- mem_rd_sts_valid/ready/data, mem_wr_sts_valid/ready/data  in/out/in  status from memory.

Behaviour:
- Reset (net_aresetn low, async): all valids and readys 0; addr/len/data registers 0; FIFOs empty; RR pointers 0. Deassertion is synchronous to net_clk.
- Command channel FSM (separate instances for rd and wr), states IDLE and HOLD.
  - IDLE: if any s_*_cmd_valid and the route FIFO is not full, pick the first valid requester at or after ptr (wrapping).
  - On that pick: pulse its s_*_cmd_ready for 1 cycle, register addr/len into the mem_*_cmd output, push the requester index into the route FIFO, set ptr=(idx+1)%NUM_REQ, go to HOLD.
  - Latency from request to mem valid is 1 cycle.
  - HOLD: mem_*_cmd_valid=1 with fields stable. On mem ready go to IDLE. The next grant is no earlier than the cycle after the handshake.
  - Route FIFO full: no s ready and no grant (backpressure).
- Read return: head of rd_route selects owner k.
  - mem_rd_data ready = m_rd_data_ready[k]; only m_rd_data_valid[k] is asserted.
  - mem_rd_sts is routed the same way; rd_route pops on the status handshake.
  - rd_route empty: all read/status valids 0, mem readys 0.
- Write data: wr_data_route (pushed at wr cmd grant) selects owner k.
  - Pass-through mux: mem_wr_data_* takes requester k; s_wr_data_ready[k]=mem_wr_data_ready.
  - Pop on the handshake with last=1.
  - Other requesters see ready=0.
  - FIFO empty: mem_wr_data_valid=0.
- Write status: wr_sts_route (pushed together with wr_data_route) routes mem_wr_sts and pops on the status handshake.
- Write path back-pressure: the write grant requires both write FIFOs not full.
- Simultaneous push and pop on a FIFO: both take effect, count unchanged. Pop on empty is impossible by construction.
- Ordering guarantee: memory returns in command order per path; the block relies on this and performs no ID matching.
- Reset mid-burst: all in-flight state is discarded. Requesters and memory are reset by the same net_aresetn.

Test Plan:
- Req0 and req1 both assert rd cmd in the same cycle with ptr=0 → req0 granted in cycle 1, mem cmd valid in cycle 2. After mem ready, req1 is granted and ptr=0 again.
- Req1 issues wr cmd len=128 with 2 beats; req0 pushes write data early → req0 ready stays 0. Req1 beats pass through; after last, wr_sts data 0x00 reaches only m_wr_sts_valid[1].
- Interleave: rd req0 (len 64), then rd req1 (len 192). Memory returns 1 beat + status, then 3 beats + status → beats and statuses land on requesters 0 and 1 respectively, in order.
- Issue 16 read cmds with mem status withheld → 17th cmd sees s_rd_cmd_ready=0 until the first status handshake, then is granted.
- Hold mem_rd_cmd_ready=0 for 5 cycles in HOLD → addr/len/valid stay stable and no other requester is granted.
- Assert net_aresetn low mid write burst → all valids 0 immediately (async). After release, a fresh wr cmd from req0 completes normally.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Shares one DDR command/data/status channel between NUM_REQ requesters (round-robin per path).
// Returning data/status is steered to its owner through in-order route FIFOs.
`timescale 1ns/1ps

module mem_req_route_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
endmodule

module mem_req_cmd_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned LEN_W   = 23,
    parameter int unsigned IDX_W   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_valid,
    output logic [NUM_REQ-1:0]        s_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  s_len,
    input  logic                      route_ok,
    output logic                      grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [LEN_W-1:0]          m_len
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [LEN_W-1:0]  len_arr  [NUM_REQ];
    int unsigned       cand;
    int unsigned       nxt;
    logic [IDX_W-1:0]  cand_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = s_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]  = s_len[g*LEN_W +: LEN_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    // Round-robin pick of the first valid requester at or after ptr_q.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        s_ready   = '0;
        grant     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        nxt       = 0;
        cand_idx  = '0;
        case (state_q)
            ST_IDLE: begin
                if (route_ok) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        cand = 32'(ptr_q) + i;
                        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                        cand_idx = IDX_W'(cand);
                        if (!grant && s_valid[cand_idx]) begin
                            grant             = 1'b1;
                            grant_idx         = cand_idx;
                            s_ready[cand_idx] = 1'b1;
                            addr_d            = addr_arr[cand_idx];
                            len_d             = len_arr[cand_idx];
                            nxt               = cand + 1;
                            ptr_d             = (nxt >= NUM_REQ) ? '0 : IDX_W'(nxt);
                            state_d           = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_valid = (state_q == ST_HOLD);
    assign m_addr  = addr_q;
    assign m_len   = len_q;
endmodule

module mem_req_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned LEN_W       = 23,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned ROUTE_DEPTH = 16
) (
    input  logic                          net_clk,
    input  logic                          net_aresetn,
    input  logic [NUM_REQ-1:0]            s_rd_cmd_valid,
    output logic [NUM_REQ-1:0]            s_rd_cmd_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_rd_cmd_addr,
    input  logic [NUM_REQ*LEN_W-1:0]      s_rd_cmd_len,
    input  logic [NUM_REQ-1:0]            s_wr_cmd_valid,
    output logic [NUM_REQ-1:0]            s_wr_cmd_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_wr_cmd_addr,
    input  logic [NUM_REQ*LEN_W-1:0]      s_wr_cmd_len,
    input  logic [NUM_REQ-1:0]            s_wr_data_valid,
    output logic [NUM_REQ-1:0]            s_wr_data_ready,
    input  logic [NUM_REQ-1:0]            s_wr_data_last,
    input  logic [NUM_REQ*DATA_W-1:0]     s_wr_data_data,
    input  logic [NUM_REQ*DATA_W/8-1:0]   s_wr_data_keep,
    output logic [NUM_REQ-1:0]            m_rd_data_valid,
    input  logic [NUM_REQ-1:0]            m_rd_data_ready,
    output logic [NUM_REQ-1:0]            m_rd_data_last,
    output logic [DATA_W-1:0]             m_rd_data_data,
    output logic [DATA_W/8-1:0]           m_rd_data_keep,
    output logic [NUM_REQ-1:0]            m_rd_sts_valid,
    input  logic [NUM_REQ-1:0]            m_rd_sts_ready,
    output logic [7:0]                    m_rd_sts_data,
    output logic [NUM_REQ-1:0]            m_wr_sts_valid,
    input  logic [NUM_REQ-1:0]            m_wr_sts_ready,
    output logic [7:0]                    m_wr_sts_data,
    output logic                          mem_rd_cmd_valid,
    input  logic                          mem_rd_cmd_ready,
    output logic [ADDR_W-1:0]             mem_rd_cmd_addr,
    output logic [LEN_W-1:0]              mem_rd_cmd_len,
    output logic                          mem_wr_cmd_valid,
    input  logic                          mem_wr_cmd_ready,
    output logic [ADDR_W-1:0]             mem_wr_cmd_addr,
    output logic [LEN_W-1:0]              mem_wr_cmd_len,
    output logic                          mem_wr_data_valid,
    input  logic                          mem_wr_data_ready,
    output logic [DATA_W-1:0]             mem_wr_data_data,
    output logic [DATA_W/8-1:0]           mem_wr_data_keep,
    output logic                          mem_wr_data_last,
    input  logic                          mem_rd_data_valid,
    output logic                          mem_rd_data_ready,
    input  logic [DATA_W-1:0]             mem_rd_data_data,
    input  logic [DATA_W/8-1:0]           mem_rd_data_keep,
    input  logic                          mem_rd_data_last,
    input  logic                          mem_rd_sts_valid,
    output logic                          mem_rd_sts_ready,
    input  logic [7:0]                    mem_rd_sts_data,
    input  logic                          mem_wr_sts_valid,
    output logic                          mem_wr_sts_ready,
    input  logic [7:0]                    mem_wr_sts_data
);
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic             rd_grant, wr_grant;
    logic [IDX_W-1:0] rd_grant_idx, wr_grant_idx;
    logic [IDX_W-1:0] rd_owner, wd_owner, ws_owner;
    logic             rd_full, wd_full, ws_full;
    logic             rd_empty, wd_empty, ws_empty;
    logic             rd_pop, wd_pop, ws_pop;
    logic [DATA_W-1:0] wr_data_arr [NUM_REQ];
    logic [KEEP_W-1:0] wr_keep_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wr_unpack
        assign wr_data_arr[g] = s_wr_data_data[g*DATA_W +: DATA_W];
        assign wr_keep_arr[g] = s_wr_data_keep[g*KEEP_W +: KEEP_W];
    end

    mem_req_cmd_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_rd_arb (
        .clk(net_clk), .rst_n(net_aresetn),
        .s_valid(s_rd_cmd_valid), .s_ready(s_rd_cmd_ready),
        .s_addr(s_rd_cmd_addr), .s_len(s_rd_cmd_len),
        .route_ok(!rd_full), .grant(rd_grant), .grant_idx(rd_grant_idx),
        .m_valid(mem_rd_cmd_valid), .m_ready(mem_rd_cmd_ready),
        .m_addr(mem_rd_cmd_addr), .m_len(mem_rd_cmd_len)
    );

    // A write grant reserves a slot in both the data and the status route.
    mem_req_cmd_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_wr_arb (
        .clk(net_clk), .rst_n(net_aresetn),
        .s_valid(s_wr_cmd_valid), .s_ready(s_wr_cmd_ready),
        .s_addr(s_wr_cmd_addr), .s_len(s_wr_cmd_len),
        .route_ok(!wd_full && !ws_full), .grant(wr_grant), .grant_idx(wr_grant_idx),
        .m_valid(mem_wr_cmd_valid), .m_ready(mem_wr_cmd_ready),
        .m_addr(mem_wr_cmd_addr), .m_len(mem_wr_cmd_len)
    );

    mem_req_route_fifo #(.DEPTH(ROUTE_DEPTH), .W(IDX_W)) u_rd_route (
        .clk(net_clk), .rst_n(net_aresetn), .push(rd_grant), .push_data(rd_grant_idx),
        .pop(rd_pop), .head(rd_owner), .full(rd_full), .empty(rd_empty)
    );

    mem_req_route_fifo #(.DEPTH(ROUTE_DEPTH), .W(IDX_W)) u_wr_data_route (
        .clk(net_clk), .rst_n(net_aresetn), .push(wr_grant), .push_data(wr_grant_idx),
        .pop(wd_pop), .head(wd_owner), .full(wd_full), .empty(wd_empty)
    );

    mem_req_route_fifo #(.DEPTH(ROUTE_DEPTH), .W(IDX_W)) u_wr_sts_route (
        .clk(net_clk), .rst_n(net_aresetn), .push(wr_grant), .push_data(wr_grant_idx),
        .pop(ws_pop), .head(ws_owner), .full(ws_full), .empty(ws_empty)
    );

    assign rd_pop = mem_rd_sts_valid && mem_rd_sts_ready;
    assign wd_pop = mem_wr_data_valid && mem_wr_data_ready && mem_wr_data_last;
    assign ws_pop = mem_wr_sts_valid && mem_wr_sts_ready;

    assign m_rd_data_data = mem_rd_data_data;
    assign m_rd_data_keep = mem_rd_data_keep;
    assign m_rd_sts_data  = mem_rd_sts_data;
    assign m_wr_sts_data  = mem_wr_sts_data;

    // Return steering: only the route-FIFO head owner sees valid; memory sees only its ready.
    always_comb begin
        m_rd_data_valid   = '0;
        m_rd_data_last    = '0;
        m_rd_sts_valid    = '0;
        m_wr_sts_valid    = '0;
        s_wr_data_ready   = '0;
        mem_rd_data_ready = 1'b0;
        mem_rd_sts_ready  = 1'b0;
        mem_wr_sts_ready  = 1'b0;
        mem_wr_data_valid = 1'b0;
        mem_wr_data_data  = '0;
        mem_wr_data_keep  = '0;
        mem_wr_data_last  = 1'b0;
        if (!rd_empty) begin
            m_rd_data_valid[rd_owner] = mem_rd_data_valid;
            m_rd_data_last[rd_owner]  = mem_rd_data_last;
            m_rd_sts_valid[rd_owner]  = mem_rd_sts_valid;
            mem_rd_data_ready         = m_rd_data_ready[rd_owner];
            mem_rd_sts_ready          = m_rd_sts_ready[rd_owner];
        end
        if (!ws_empty) begin
            m_wr_sts_valid[ws_owner] = mem_wr_sts_valid;
            mem_wr_sts_ready         = m_wr_sts_ready[ws_owner];
        end
        if (!wd_empty) begin
            mem_wr_data_valid         = s_wr_data_valid[wd_owner];
            mem_wr_data_data          = wr_data_arr[wd_owner];
            mem_wr_data_keep          = wr_keep_arr[wd_owner];
            mem_wr_data_last          = s_wr_data_last[wd_owner];
            s_wr_data_ready[wd_owner] = mem_wr_data_ready;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: table of round-robin read grants plus multi-cycle sequences.
`timescale 1ns/1ps

module tb_mem_req_arbiter;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned LEN_W   = 23;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned KEEP_W  = DATA_W / 8;
    localparam int unsigned DEPTH   = 16;

    localparam logic [ADDR_W-1:0] RA0 = 64'h1000;
    localparam logic [ADDR_W-1:0] RA1 = 64'h2000;
    localparam logic [LEN_W-1:0]  RL0 = 23'd64;
    localparam logic [LEN_W-1:0]  RL1 = 23'd192;

    logic                        net_clk;
    logic                        net_aresetn;
    logic [NUM_REQ-1:0]          s_rd_cmd_valid, s_rd_cmd_ready;
    logic [NUM_REQ*ADDR_W-1:0]   s_rd_cmd_addr;
    logic [NUM_REQ*LEN_W-1:0]    s_rd_cmd_len;
    logic [NUM_REQ-1:0]          s_wr_cmd_valid, s_wr_cmd_ready;
    logic [NUM_REQ*ADDR_W-1:0]   s_wr_cmd_addr;
    logic [NUM_REQ*LEN_W-1:0]    s_wr_cmd_len;
    logic [NUM_REQ-1:0]          s_wr_data_valid, s_wr_data_ready, s_wr_data_last;
    logic [NUM_REQ*DATA_W-1:0]   s_wr_data_data;
    logic [NUM_REQ*KEEP_W-1:0]   s_wr_data_keep;
    logic [NUM_REQ-1:0]          m_rd_data_valid, m_rd_data_ready, m_rd_data_last;
    logic [DATA_W-1:0]           m_rd_data_data;
    logic [KEEP_W-1:0]           m_rd_data_keep;
    logic [NUM_REQ-1:0]          m_rd_sts_valid, m_rd_sts_ready;
    logic [7:0]                  m_rd_sts_data;
    logic [NUM_REQ-1:0]          m_wr_sts_valid, m_wr_sts_ready;
    logic [7:0]                  m_wr_sts_data;
    logic                        mem_rd_cmd_valid, mem_rd_cmd_ready;
    logic [ADDR_W-1:0]           mem_rd_cmd_addr;
    logic [LEN_W-1:0]            mem_rd_cmd_len;
    logic                        mem_wr_cmd_valid, mem_wr_cmd_ready;
    logic [ADDR_W-1:0]           mem_wr_cmd_addr;
    logic [LEN_W-1:0]            mem_wr_cmd_len;
    logic                        mem_wr_data_valid, mem_wr_data_ready, mem_wr_data_last;
    logic [DATA_W-1:0]           mem_wr_data_data;
    logic [KEEP_W-1:0]           mem_wr_data_keep;
    logic                        mem_rd_data_valid, mem_rd_data_ready, mem_rd_data_last;
    logic [DATA_W-1:0]           mem_rd_data_data;
    logic [KEEP_W-1:0]           mem_rd_data_keep;
    logic                        mem_rd_sts_valid, mem_rd_sts_ready;
    logic [7:0]                  mem_rd_sts_data;
    logic                        mem_wr_sts_valid, mem_wr_sts_ready;
    logic [7:0]                  mem_wr_sts_data;

    mem_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .ROUTE_DEPTH(DEPTH)
    ) dut (
        .net_clk(net_clk), .net_aresetn(net_aresetn),
        .s_rd_cmd_valid(s_rd_cmd_valid), .s_rd_cmd_ready(s_rd_cmd_ready),
        .s_rd_cmd_addr(s_rd_cmd_addr), .s_rd_cmd_len(s_rd_cmd_len),
        .s_wr_cmd_valid(s_wr_cmd_valid), .s_wr_cmd_ready(s_wr_cmd_ready),
        .s_wr_cmd_addr(s_wr_cmd_addr), .s_wr_cmd_len(s_wr_cmd_len),
        .s_wr_data_valid(s_wr_data_valid), .s_wr_data_ready(s_wr_data_ready),
        .s_wr_data_last(s_wr_data_last), .s_wr_data_data(s_wr_data_data),
        .s_wr_data_keep(s_wr_data_keep),
        .m_rd_data_valid(m_rd_data_valid), .m_rd_data_ready(m_rd_data_ready),
        .m_rd_data_last(m_rd_data_last), .m_rd_data_data(m_rd_data_data),
        .m_rd_data_keep(m_rd_data_keep),
        .m_rd_sts_valid(m_rd_sts_valid), .m_rd_sts_ready(m_rd_sts_ready),
        .m_rd_sts_data(m_rd_sts_data),
        .m_wr_sts_valid(m_wr_sts_valid), .m_wr_sts_ready(m_wr_sts_ready),
        .m_wr_sts_data(m_wr_sts_data),
        .mem_rd_cmd_valid(mem_rd_cmd_valid), .mem_rd_cmd_ready(mem_rd_cmd_ready),
        .mem_rd_cmd_addr(mem_rd_cmd_addr), .mem_rd_cmd_len(mem_rd_cmd_len),
        .mem_wr_cmd_valid(mem_wr_cmd_valid), .mem_wr_cmd_ready(mem_wr_cmd_ready),
        .mem_wr_cmd_addr(mem_wr_cmd_addr), .mem_wr_cmd_len(mem_wr_cmd_len),
        .mem_wr_data_valid(mem_wr_data_valid), .mem_wr_data_ready(mem_wr_data_ready),
        .mem_wr_data_data(mem_wr_data_data), .mem_wr_data_keep(mem_wr_data_keep),
        .mem_wr_data_last(mem_wr_data_last),
        .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data_ready(mem_rd_data_ready),
        .mem_rd_data_data(mem_rd_data_data), .mem_rd_data_keep(mem_rd_data_keep),
        .mem_rd_data_last(mem_rd_data_last),
        .mem_rd_sts_valid(mem_rd_sts_valid), .mem_rd_sts_ready(mem_rd_sts_ready),
        .mem_rd_sts_data(mem_rd_sts_data),
        .mem_wr_sts_valid(mem_wr_sts_valid), .mem_wr_sts_ready(mem_wr_sts_ready),
        .mem_wr_sts_data(mem_wr_sts_data)
    );

    initial net_clk = 1'b0;
    always #5 net_clk = ~net_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exp_ready;
    } rd_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change only 1 ns after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge net_clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_rd_cmd_valid = '0;  s_rd_cmd_addr = {RA1, RA0}; s_rd_cmd_len = {RL1, RL0};
        s_wr_cmd_valid = '0;  s_wr_cmd_addr = '0;         s_wr_cmd_len = '0;
        s_wr_data_valid = '0; s_wr_data_last = '0; s_wr_data_data = '0; s_wr_data_keep = '1;
        m_rd_data_ready = '0; m_rd_sts_ready = '0; m_wr_sts_ready = '0;
        mem_rd_cmd_ready = 1'b0; mem_wr_cmd_ready = 1'b0; mem_wr_data_ready = 1'b0;
        mem_rd_data_valid = 1'b0; mem_rd_data_data = '0; mem_rd_data_keep = '1;
        mem_rd_data_last = 1'b0;
        mem_rd_sts_valid = 1'b0; mem_rd_sts_data = '0;
        mem_wr_sts_valid = 1'b0; mem_wr_sts_data = '0;
    endtask

    // One read command from the requesters in mask, expected to grant exactly mask, then acked.
    task automatic rd_cmd(input logic [1:0] mask);
        s_rd_cmd_valid = mask;
        @(negedge net_clk);
        chk("rd_grant", 64'(s_rd_cmd_ready), 64'(mask));
        tick();
        s_rd_cmd_valid = '0;
        @(negedge net_clk);
        mem_rd_cmd_ready = 1'b1;
        tick();
        mem_rd_cmd_ready = 1'b0;
    endtask

    rd_vec_t    vecs [8];
    logic [1:0] own;

    initial begin
        // Pointer starts at 0 and moves to winner+1 on every grant.
        vecs[0] = '{2'b11, 2'b01};
        vecs[1] = '{2'b11, 2'b10};
        vecs[2] = '{2'b10, 2'b10};
        vecs[3] = '{2'b10, 2'b10};
        vecs[4] = '{2'b01, 2'b01};
        vecs[5] = '{2'b01, 2'b01};
        vecs[6] = '{2'b00, 2'b00};
        vecs[7] = '{2'b11, 2'b10};

        idle_inputs();
        net_aresetn = 1'b0;
        repeat (2) @(negedge net_clk);
        chk("rst_rd_cmd_valid", 64'(mem_rd_cmd_valid), 64'd0);
        chk("rst_wr_cmd_valid", 64'(mem_wr_cmd_valid), 64'd0);
        chk("rst_wr_data_valid", 64'(mem_wr_data_valid), 64'd0);
        chk("rst_rd_cmd_addr", mem_rd_cmd_addr, 64'd0);
        chk("rst_rd_cmd_ready", 64'(s_rd_cmd_ready), 64'd0);
        net_aresetn = 1'b1;
        tick();

        // Round-robin grant table
        m_rd_sts_ready = 2'b11;
        for (int v = 0; v < 8; v++) begin
            s_rd_cmd_valid = vecs[v].valid;
            @(negedge net_clk);
            chk("rr_ready", 64'(s_rd_cmd_ready), 64'(vecs[v].exp_ready));
            tick();
            s_rd_cmd_valid = '0;
            @(negedge net_clk);
            if (vecs[v].exp_ready != 2'b00) begin
                chk("rr_mem_valid", 64'(mem_rd_cmd_valid), 64'd1);
                chk("rr_mem_addr", mem_rd_cmd_addr, vecs[v].exp_ready[1] ? RA1 : RA0);
                chk("rr_mem_len", 64'(mem_rd_cmd_len), 64'(vecs[v].exp_ready[1] ? RL1 : RL0));
                mem_rd_cmd_ready = 1'b1;
                tick();
                mem_rd_cmd_ready = 1'b0;
                mem_rd_sts_valid = 1'b1;
                @(negedge net_clk);
                chk("rr_sts_route", 64'(m_rd_sts_valid), 64'(vecs[v].exp_ready));
                tick();
                mem_rd_sts_valid = 1'b0;
            end else begin
                chk("rr_idle_mem_valid", 64'(mem_rd_cmd_valid), 64'd0);
                tick();
            end
        end

        // Both request together, mem ready held low 5 cycles in HOLD
        s_rd_cmd_valid = 2'b11;
        @(negedge net_clk);
        chk("both_grant0", 64'(s_rd_cmd_ready), 64'b01);
        tick();
        s_rd_cmd_valid = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge net_clk);
            chk("hold_valid", 64'(mem_rd_cmd_valid), 64'd1);
            chk("hold_addr", mem_rd_cmd_addr, RA0);
            chk("hold_no_grant", 64'(s_rd_cmd_ready), 64'd0);
            if (c == 4) mem_rd_cmd_ready = 1'b1;
            tick();
        end
        mem_rd_cmd_ready = 1'b0;
        @(negedge net_clk);
        chk("then_grant1", 64'(s_rd_cmd_ready), 64'b10);
        tick();
        s_rd_cmd_valid = '0;
        @(negedge net_clk);
        chk("then_addr1", mem_rd_cmd_addr, RA1);
        mem_rd_cmd_ready = 1'b1;
        tick();
        mem_rd_cmd_ready = 1'b0;
        rd_cmd(2'b01);
        s_rd_cmd_valid = '0;
        mem_rd_sts_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge net_clk);
            chk("hold_drain", 64'(m_rd_sts_valid), (c == 1) ? 64'b10 : 64'b01);
            tick();
        end
        mem_rd_sts_valid = 1'b0;

        // Write: req0 data early is blocked, req1 bursts through
        s_wr_data_valid = 2'b01;
        s_wr_data_last  = 2'b01;
        s_wr_data_data  = {64'h0, 64'hDEAD};
        mem_wr_data_ready = 1'b1;
        @(negedge net_clk);
        chk("wr_early_ready", 64'(s_wr_data_ready), 64'd0);
        chk("wr_early_valid", 64'(mem_wr_data_valid), 64'd0);
        tick();
        s_wr_cmd_valid = 2'b10;
        s_wr_cmd_addr  = {64'h3000, 64'h0};
        s_wr_cmd_len   = {23'd128, 23'd0};
        @(negedge net_clk);
        chk("wr_grant1", 64'(s_wr_cmd_ready), 64'b10);
        tick();
        s_wr_cmd_valid = '0;
        @(negedge net_clk);
        chk("wr_cmd_addr", mem_wr_cmd_addr, 64'h3000);
        chk("wr_cmd_len", 64'(mem_wr_cmd_len), 64'd128);
        mem_wr_cmd_ready = 1'b1;
        tick();
        mem_wr_cmd_ready = 1'b0;
        s_wr_data_valid = 2'b11;
        s_wr_data_data  = {64'hB1, 64'hDEAD};
        @(negedge net_clk);
        chk("wr_b1_ready", 64'(s_wr_data_ready), 64'b10);
        chk("wr_b1_data", mem_wr_data_data, 64'hB1);
        chk("wr_b1_last", 64'(mem_wr_data_last), 64'd0);
        tick();
        s_wr_data_data = {64'hB2, 64'hDEAD};
        s_wr_data_last = 2'b11;
        @(negedge net_clk);
        chk("wr_b2_data", mem_wr_data_data, 64'hB2);
        chk("wr_b2_last", 64'(mem_wr_data_last), 64'd1);
        tick();
        s_wr_data_valid = 2'b01;
        @(negedge net_clk);
        chk("wr_after_ready", 64'(s_wr_data_ready), 64'd0);
        chk("wr_after_valid", 64'(mem_wr_data_valid), 64'd0);
        tick();
        mem_wr_sts_valid = 1'b1;
        m_wr_sts_ready   = 2'b11;
        @(negedge net_clk);
        chk("wr_sts_route", 64'(m_wr_sts_valid), 64'b10);
        chk("wr_sts_data", 64'(m_wr_sts_data), 64'h00);
        tick();
        mem_wr_sts_valid = 1'b0;
        s_wr_data_valid  = '0;

        // Interleaved reads: 1 beat to req0, 3 beats to req1
        rd_cmd(2'b01);
        rd_cmd(2'b10);
        m_rd_data_ready   = 2'b11;
        mem_rd_data_valid = 1'b1;
        mem_rd_data_data  = 64'hA0;
        mem_rd_data_last  = 1'b1;
        @(negedge net_clk);
        chk("il_r0_valid", 64'(m_rd_data_valid), 64'b01);
        chk("il_r0_last", 64'(m_rd_data_last), 64'b01);
        chk("il_r0_data", m_rd_data_data, 64'hA0);
        chk("il_r0_mem_ready", 64'(mem_rd_data_ready), 64'd1);
        tick();
        mem_rd_data_valid = 1'b0;
        mem_rd_sts_valid  = 1'b1;
        mem_rd_sts_data   = 8'h00;
        @(negedge net_clk);
        chk("il_s0_valid", 64'(m_rd_sts_valid), 64'b01);
        tick();
        mem_rd_sts_valid  = 1'b0;
        mem_rd_data_valid = 1'b1;
        mem_rd_data_last  = 1'b0;
        mem_rd_data_data  = 64'hB0;
        m_rd_data_ready   = 2'b01;
        @(negedge net_clk);
        chk("il_owner_stall", 64'(mem_rd_data_ready), 64'd0);
        chk("il_r1_valid0", 64'(m_rd_data_valid), 64'b10);
        tick();
        m_rd_data_ready = 2'b11;
        for (int b = 0; b < 3; b++) begin
            mem_rd_data_data = 64'hB0 + 64'(b);
            mem_rd_data_last = (b == 2);
            @(negedge net_clk);
            chk("il_r1_valid", 64'(m_rd_data_valid), 64'b10);
            chk("il_r1_data", m_rd_data_data, 64'hB0 + 64'(b));
            tick();
        end
        mem_rd_data_valid = 1'b0;
        mem_rd_sts_valid  = 1'b1;
        mem_rd_sts_data   = 8'h01;
        @(negedge net_clk);
        chk("il_s1_valid", 64'(m_rd_sts_valid), 64'b10);
        chk("il_s1_data", 64'(m_rd_sts_data), 64'h01);
        tick();
        mem_rd_sts_valid  = 1'b0;
        mem_rd_data_valid = 1'b1;
        @(negedge net_clk);
        chk("empty_mem_ready", 64'(mem_rd_data_ready), 64'd0);
        chk("empty_rd_valid", 64'(m_rd_data_valid), 64'd0);
        tick();
        mem_rd_data_valid = 1'b0;
        mem_rd_data_last  = 1'b0;

        // Fill read route FIFO, 17th command waits for first status
        for (int i = 0; i < DEPTH; i++) rd_cmd(2'b01);
        s_rd_cmd_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge net_clk);
            chk("full_no_ready", 64'(s_rd_cmd_ready), 64'd0);
            tick();
        end
        mem_rd_sts_valid = 1'b1;
        @(negedge net_clk);
        chk("full_pop_cycle", 64'(s_rd_cmd_ready), 64'd0);
        tick();
        mem_rd_sts_valid = 1'b0;
        @(negedge net_clk);
        chk("full_released", 64'(s_rd_cmd_ready), 64'b01);
        tick();
        s_rd_cmd_valid = '0;
        @(negedge net_clk);
        chk("full_cmd_valid", 64'(mem_rd_cmd_valid), 64'd1);
        mem_rd_cmd_ready = 1'b1;
        tick();
        mem_rd_cmd_ready = 1'b0;
        mem_rd_sts_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge net_clk);
            chk("full_drain", 64'(m_rd_sts_valid), 64'b01);
            tick();
        end
        mem_rd_sts_valid = 1'b0;

        // Reset in the middle of a write burst
        s_wr_cmd_valid = 2'b01;
        s_wr_cmd_addr  = {64'h0, 64'h4000};
        s_wr_cmd_len   = {23'd0, 23'd64};
        @(negedge net_clk);
        chk("mid_wr_grant", 64'(s_wr_cmd_ready), 64'b01);
        tick();
        s_wr_cmd_valid = '0;
        @(negedge net_clk);
        mem_wr_cmd_ready = 1'b1;
        tick();
        mem_wr_cmd_ready  = 1'b0;
        s_rd_cmd_valid    = 2'b01;
        s_wr_data_valid   = 2'b01;
        s_wr_data_last    = 2'b00;
        s_wr_data_data    = {64'h0, 64'hC0};
        mem_wr_data_ready = 1'b1;
        tick();
        s_rd_cmd_valid = '0;
        @(negedge net_clk);
        chk("mid_wr_valid", 64'(mem_wr_data_valid), 64'd1);
        chk("mid_rd_hold", 64'(mem_rd_cmd_valid), 64'd1);
        #2;
        net_aresetn = 1'b0;
        #1;
        chk("arst_wr_valid", 64'(mem_wr_data_valid), 64'd0);
        chk("arst_rd_cmd", 64'(mem_rd_cmd_valid), 64'd0);
        chk("arst_wr_ready", 64'(s_wr_data_ready), 64'd0);
        idle_inputs();
        @(negedge net_clk);
        net_aresetn = 1'b1;
        tick();
        s_wr_cmd_valid = 2'b01;
        s_wr_cmd_addr  = {64'h0, 64'h5000};
        s_wr_cmd_len   = {23'd0, 23'd64};
        @(negedge net_clk);
        chk("post_wr_grant", 64'(s_wr_cmd_ready), 64'b01);
        tick();
        s_wr_cmd_valid = '0;
        @(negedge net_clk);
        chk("post_wr_addr", mem_wr_cmd_addr, 64'h5000);
        mem_wr_cmd_ready = 1'b1;
        tick();
        mem_wr_cmd_ready  = 1'b0;
        s_wr_data_valid   = 2'b01;
        s_wr_data_last    = 2'b01;
        s_wr_data_data    = {64'h0, 64'hC1};
        mem_wr_data_ready = 1'b1;
        @(negedge net_clk);
        chk("post_wr_data", mem_wr_data_data, 64'hC1);
        chk("post_wr_ready", 64'(s_wr_data_ready), 64'b01);
        tick();
        s_wr_data_valid  = '0;
        mem_wr_sts_valid = 1'b1;
        m_wr_sts_ready   = 2'b11;
        @(negedge net_clk);
        own = m_wr_sts_valid;
        chk("post_wr_sts", 64'(own), 64'b01);
        tick();
        mem_wr_sts_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
